// File: rtl/sha256_padder.sv
// SHA-256 message padder: 64-bit big-endian beats in, padded 64-bit words out.
// Optional sticky pad_err output when SHA_PAD_ERR_EN is defined.
//
// Ports:
//   clk, n_rst    clock (rising edge), asynchronous active-low reset
//   clear         synchronous abort, highest priority
//   in_data       message beat, byte 0 = in_data[63:56]
//   in_valid      in_data valid
//   in_last       final beat of message
//   in_bytes      valid bytes on last beat (0..8, MSB-aligned; 9..15 act as 8)
//   in_ready      beat accepted when in_valid && in_ready
//   out_data      padded word (register)
//   out_valid     out_data valid
//   out_ready     downstream accepts word
//   out_blk_end   out_data is word 7 of a 512-bit block
//   pad_err       (SHA_PAD_ERR_EN only) sticky: last beat had in_bytes > 8
//   msg_done      one-cycle pulse after the length word is accepted
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [3:0]  in_bytes,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_blk_end,
`ifdef SHA_PAD_ERR_EN
    output logic        pad_err,
`endif
    output logic        msg_done
);

    typedef enum logic [2:0] {
        S_DATA,
        S_PAD80,
        S_ZERO,
        S_LEN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             nxt;
    logic [2:0]         idx;
    logic [LEN_W-1:0]   byte_cnt;
    logic [LEN_W-1:0]   bit_len;
    logic [63:0]        len_word;
    logic               ld;
    logic               accept;
    logic               xfer;
    logic [3:0]         eff;
    logic               load_en;
    logic [63:0]        load_word;
    state_t             pad_next;

    // Keep bytes below n, then 0x80, then zero fill.
    function automatic logic [63:0] pad_beat(input logic [63:0] d,
                                             input logic [3:0]  n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n))
                r[63-8*i -: 8] = d[63-8*i -: 8];
            else if (i == int'(n))
                r[63-8*i -: 8] = 8'h80;
        end
        return r;
    endfunction

    assign ld       = !out_valid || out_ready;
    assign xfer     = out_valid && out_ready;
    assign in_ready = (state == S_DATA) && ld && !clear;
    assign accept   = in_valid && in_ready;
    assign eff      = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign bit_len  = byte_cnt << 3;
    assign len_word = 64'(bit_len);

    // The 0x80 word decides whether the length still fits in this block:
    // only a 0x80 word at idx 6 leaves exactly one slot (idx 7) for it.
    assign pad_next = (idx == 3'd6) ? S_LEN : S_ZERO;

    always_comb begin
        load_en   = 1'b0;
        load_word = '0;
        nxt       = state;
        unique case (state)
            S_DATA: begin
                if (accept) begin
                    load_en = 1'b1;
                    if (in_last && (eff < 4'd8)) begin
                        load_word = pad_beat(in_data, eff);
                        nxt       = pad_next;
                    end else begin
                        load_word = in_data;
                        nxt       = in_last ? S_PAD80 : S_DATA;
                    end
                end
            end
            S_PAD80: begin
                if (ld) begin
                    load_en   = 1'b1;
                    load_word = 64'h8000_0000_0000_0000;
                    nxt       = pad_next;
                end
            end
            S_ZERO: begin
                if (ld) begin
                    load_en = 1'b1;
                    nxt     = (idx == 3'd6) ? S_LEN : S_ZERO;
                end
            end
            S_LEN: begin
                if (ld) begin
                    load_en   = 1'b1;
                    load_word = len_word;
                    nxt       = S_DONE;
                end
            end
            S_DONE: begin
                if (xfer)
                    nxt = S_DATA;
            end
            default: nxt = S_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_DATA;
            idx         <= '0;
            byte_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_blk_end <= 1'b0;
            msg_done    <= 1'b0;
`ifdef SHA_PAD_ERR_EN
            pad_err     <= 1'b0;
`endif
        end else if (clear) begin
            state       <= S_DATA;
            idx         <= '0;
            byte_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_blk_end <= 1'b0;
            msg_done    <= 1'b0;
`ifdef SHA_PAD_ERR_EN
            pad_err     <= 1'b0;
`endif
        end else begin
            msg_done <= 1'b0;
            state    <= nxt;

            if (load_en) begin
                out_data    <= load_word;
                out_valid   <= 1'b1;
                out_blk_end <= (idx == 3'd7);
                idx         <= idx + 3'd1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            if (accept)
                byte_cnt <= byte_cnt + LEN_W'(in_last ? eff : 4'd8);

            if ((state == S_DONE) && xfer) begin
                msg_done <= 1'b1;
                byte_cnt <= '0;
                idx      <= '0;
            end

`ifdef SHA_PAD_ERR_EN
            if (accept && in_last && (in_bytes > 4'd8))
                pad_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized scoreboard bench for sha256_padder.
// Expected words come from a byte-level padding model built per message.
module tb_sha256_padder;

    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [3:0]  in_bytes = '0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_blk_end;
    logic        msg_done;
`ifdef SHA_PAD_ERR_EN
    logic        pad_err;
`endif

    sha256_padder #(.LEN_W(64)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_blk_end (out_blk_end),
`ifdef SHA_PAD_ERR_EN
        .pad_err     (pad_err),
`endif
        .msg_done    (msg_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        be;
        logic        last;
    } exp_t;

    exp_t         q[$];
    exp_t         e_mon;
    byte unsigned msg[$];
    int           checks = 0;
    int           errors = 0;
    int           ready_pct = 100;
    logic         mon_en = 1'b0;
    logic         illegal_sent = 1'b0;
    logic         done_exp = 1'b0;
    logic         held_v = 1'b0;
    logic [63:0]  held_d = '0;
    logic         held_be = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
    function automatic void push_expected();
        byte unsigned p[$];
        logic [63:0]  bl;
        exp_t         e;
        int           nw;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56)
            p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--)
            p.push_back(bl[8*i +: 8]);
        nw = p.size() / 8;
        for (int w = 0; w < nw; w++) begin
            e.d = '0;
            for (int k = 0; k < 8; k++)
                e.d = {e.d[55:0], p[8*w+k]};
            e.be   = (w % 8 == 7);
            e.last = (w == nw - 1);
            q.push_back(e);
        end
    endfunction

    always begin
        @(posedge clk);
        #1;
        out_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end

    always @(negedge clk) begin
        if (!mon_en) begin
            held_v   = 1'b0;
            done_exp = 1'b0;
        end else begin
            if (done_exp || msg_done)
                chk("msg_done", 64'(msg_done), 64'(done_exp));
            done_exp = 1'b0;
            if (held_v && out_valid) begin
                chk("stall_data", out_data, held_d);
                chk("stall_blk_end", 64'(out_blk_end), 64'(held_be));
            end
            if (out_valid && out_ready) begin
                held_v = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(out_valid), 64'd0);
                end else begin
                    e_mon = q.pop_front();
                    chk("out_data", out_data, e_mon.d);
                    chk("out_blk_end", 64'(out_blk_end), 64'(e_mon.be));
                    done_exp = e_mon.last;
                end
            end else if (out_valid) begin
                held_v  = 1'b1;
                held_d  = out_data;
                held_be = out_blk_end;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic last,
                              input logic [3:0] nb);
        bit acc;
        int c;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_bytes = nb;
        c = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc)
                break;
            c++;
            if (c >= BUDGET) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: waited %0d cycles", c);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_msg(input bit illegal_ok);
        int          n;
        int          nbeats;
        logic [63:0] w;
        logic        last;
        logic [3:0]  nb;
        n = msg.size();
        push_expected();
        nbeats = (n == 0) ? 1 : (n + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            w = '0;
            for (int k = 0; k < 8; k++)
                w = {w[55:0], (8*b + k < n) ? msg[8*b+k] : 8'($urandom)};
            last = (b == nbeats - 1);
            nb = last ? 4'(n - 8*b) : 4'($urandom);
            if (last && nb == 4'd8 && illegal_ok && $urandom_range(0, 1) == 1) begin
                nb = 4'($urandom_range(9, 15));
                illegal_sent = 1'b1;
            end
            drive_beat(w, last, nb);
        end
    endtask

    task automatic rand_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++)
            msg.push_back(8'($urandom));
    endtask

    task automatic abc_msg();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q.size() != 0 || out_valid) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_blk_end", 64'(out_blk_end), 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
`ifdef SHA_PAD_ERR_EN
        chk("rst_pad_err", 64'(pad_err), 64'd0);
`endif
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        abc_msg();
        send_msg(1'b0);
        drain();
        msg.delete();
        send_msg(1'b0);
        drain();
        rand_msg(56);
        send_msg(1'b0);
        drain();
        rand_msg(64);
        send_msg(1'b0);
        drain();

        ready_pct = 40;
        abc_msg();
        send_msg(1'b0);
        drain();

        for (int m = 0; m < 25; m++) begin
            ready_pct = int'($urandom_range(30, 100));
            rand_msg(int'($urandom_range(0, 140)));
            send_msg(1'b1);
        end
        drain();
`ifdef SHA_PAD_ERR_EN
        chk("pad_err_sticky", 64'(pad_err), 64'(illegal_sent));
`endif

        ready_pct = 100;
        mon_en = 1'b0;
        for (int b = 0; b < 3; b++)
            drive_beat({$urandom, $urandom}, 1'b0, 4'd8);
        in_data  = {$urandom, $urandom};
        in_valid = 1'b1;
        in_last  = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clear_out_valid", 64'(out_valid), 64'd0);
        chk("clear_msg_done", 64'(msg_done), 64'd0);
`ifdef SHA_PAD_ERR_EN
        chk("clear_pad_err", 64'(pad_err), 64'd0);
`endif
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        abc_msg();
        send_msg(1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
